// File: rtl/fetch_inst_queue_if.sv
// rtl/fetch_inst_queue_if.sv - fetch-to-decode bundle interface of the fetch instruction queue

`ifndef SIZE_INSTRUCTION
`define SIZE_INSTRUCTION 32
`endif
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef SIZE_CTI_LOG
`define SIZE_CTI_LOG 4
`endif

interface fetch_inst_queue_if #(
    parameter int DEPTH = 16,
    parameter int PKT_W = `SIZE_INSTRUCTION + 2*`SIZE_PC + `SIZE_CTI_LOG + 1
);
    logic                     flush_i;
    logic                     fs2Ready_i;
    logic [3:0]               instValid_i;
    logic [PKT_W-1:0]         inst0Packet_i;
    logic [PKT_W-1:0]         inst1Packet_i;
    logic [PKT_W-1:0]         inst2Packet_i;
    logic [PKT_W-1:0]         inst3Packet_i;
    logic                     decStall_i;
    logic                     fetchStall_o;
    logic [3:0]               decValid_o;
    logic [PKT_W-1:0]         dec0Packet_o;
    logic [PKT_W-1:0]         dec1Packet_o;
    logic [PKT_W-1:0]         dec2Packet_o;
    logic [PKT_W-1:0]         dec3Packet_o;
    logic [$clog2(DEPTH):0]   occupancy_o;

    modport master (
        output flush_i, fs2Ready_i, instValid_i,
        output inst0Packet_i, inst1Packet_i, inst2Packet_i, inst3Packet_i,
        output decStall_i,
        input  fetchStall_o, decValid_o, occupancy_o,
        input  dec0Packet_o, dec1Packet_o, dec2Packet_o, dec3Packet_o
    );

    modport slave (
        input  flush_i, fs2Ready_i, instValid_i,
        input  inst0Packet_i, inst1Packet_i, inst2Packet_i, inst3Packet_i,
        input  decStall_i,
        output fetchStall_o, decValid_o, occupancy_o,
        output dec0Packet_o, dec1Packet_o, dec2Packet_o, dec3Packet_o
    );
endinterface

// File: rtl/fetch_inst_queue.sv
// rtl/fetch_inst_queue.sv - 4-wide compacting circular queue between fetch stage 2 and decode

`ifndef SIZE_INSTRUCTION
`define SIZE_INSTRUCTION 32
`endif
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef SIZE_CTI_LOG
`define SIZE_CTI_LOG 4
`endif

module fetch_inst_queue #(
    parameter int DEPTH = 16,
    parameter int PKT_W = `SIZE_INSTRUCTION + 2*`SIZE_PC + `SIZE_CTI_LOG + 1
) (
    input logic              clk,
    input logic              reset,
    fetch_inst_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [PKT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [OCC_W-1:0] occupancy;

    logic [PKT_W-1:0] inPkt [4];
    logic [PTR_W-1:0] rank [4];
    logic [2:0]       nE;
    logic [2:0]       nD;
    logic             enq;

    assign inPkt[0] = q.inst0Packet_i;
    assign inPkt[1] = q.inst1Packet_i;
    assign inPkt[2] = q.inst2Packet_i;
    assign inPkt[3] = q.inst3Packet_i;

    // Stall depends only on registered occupancy, so fetch never sees a combinational loop through decode.
    assign q.fetchStall_o = (OCC_W'(DEPTH) - occupancy) < OCC_W'(4);
    assign q.occupancy_o  = occupancy;

    for (genvar k = 0; k < 4; k++) begin : gDecValid
        assign q.decValid_o[k] = (occupancy > OCC_W'(k)) & ~q.flush_i;
    end

    assign q.dec0Packet_o = mem[head];
    assign q.dec1Packet_o = mem[head + PTR_W'(1)];
    assign q.dec2Packet_o = mem[head + PTR_W'(2)];
    assign q.dec3Packet_o = mem[head + PTR_W'(3)];

    assign enq = q.fs2Ready_i & ~q.fetchStall_o & ~q.flush_i;

    // Rank of each valid slot among the valid slots below it; compacts holes out of the bundle.
    always_comb begin
        rank[0] = '0;
        rank[1] = PTR_W'(q.instValid_i[0]);
        rank[2] = rank[1] + PTR_W'(q.instValid_i[1]);
        rank[3] = rank[2] + PTR_W'(q.instValid_i[2]);
        nE = 3'd0;
        if (enq) begin
            nE = {2'b00, q.instValid_i[0]} + {2'b00, q.instValid_i[1]}
               + {2'b00, q.instValid_i[2]} + {2'b00, q.instValid_i[3]};
        end
        nD = 3'd0;
        if (!q.decStall_i) begin
            nD = {2'b00, q.decValid_o[0]} + {2'b00, q.decValid_o[1]}
               + {2'b00, q.decValid_o[2]} + {2'b00, q.decValid_o[3]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else if (q.flush_i) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            head      <= head + PTR_W'(nD);
            tail      <= tail + PTR_W'(nE);
            occupancy <= occupancy + OCC_W'(nE) - OCC_W'(nD);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (enq && q.instValid_i[k]) begin
                mem[tail + rank[k]] <= inPkt[k];
            end
        end
    end
endmodule

// File: tb/tb_fetch_inst_queue.sv
// tb/tb_fetch_inst_queue.sv - scoreboard bench for fetch_inst_queue
module tb_fetch_inst_queue;
    localparam int DEPTH = 16;
    localparam int PKT_W = 101;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fetch_inst_queue_if #(.DEPTH(DEPTH), .PKT_W(PKT_W)) bus ();
    fetch_inst_queue #(.DEPTH(DEPTH), .PKT_W(PKT_W)) dut (.clk(clk), .reset(reset), .q(bus));

    int compared = 0;
    int mismatched = 0;
    int seq = 0;
    logic [PKT_W-1:0] expQ [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [PKT_W-1:0] mkPkt(input int n);
        return {5'h15, 64'hCAFE_0000_0000_0000 | 64'(n), 32'(n * 3 + 1)};
    endfunction

    task automatic cycle(input logic fs2, input logic [3:0] v, input logic stall, input logic fl);
        @(posedge clk);
        #1;
        bus.fs2Ready_i    = fs2;
        bus.instValid_i   = v;
        bus.decStall_i    = stall;
        bus.flush_i       = fl;
        bus.inst0Packet_i = mkPkt(seq);
        bus.inst1Packet_i = mkPkt(seq + 1);
        bus.inst2Packet_i = mkPkt(seq + 2);
        bus.inst3Packet_i = mkPkt(seq + 3);
        seq += 4;
    endtask

    always @(negedge reset) expQ.delete();

    // Monitor: compare outputs against the expected queue, then advance it for the coming edge.
    always @(negedge clk) begin : monitor
        int occ;
        int nd;
        logic es;
        logic [3:0] ev;
        logic [PKT_W-1:0] dec [4];
        logic [PKT_W-1:0] pk [4];
        if (!reset) begin
            check("reset_occupancy", 128'(bus.occupancy_o), 128'(0));
            check("reset_decValid", 128'(bus.decValid_o), 128'(0));
            check("reset_fetchStall", 128'(bus.fetchStall_o), 128'(0));
            expQ.delete();
        end else begin
            occ = expQ.size();
            es  = (DEPTH - occ) < 4;
            for (int k = 0; k < 4; k++) ev[k] = (occ > k) && !bus.flush_i;
            check("occupancy", 128'(bus.occupancy_o), 128'(occ));
            check("fetchStall", 128'(bus.fetchStall_o), 128'(es));
            check("decValid", 128'(bus.decValid_o), 128'(ev));
            dec[0] = bus.dec0Packet_o; dec[1] = bus.dec1Packet_o;
            dec[2] = bus.dec2Packet_o; dec[3] = bus.dec3Packet_o;
            for (int k = 0; k < 4; k++)
                if (ev[k]) check($sformatf("dec%0dPacket", k), 128'(dec[k]), 128'(expQ[k]));
            pk[0] = bus.inst0Packet_i; pk[1] = bus.inst1Packet_i;
            pk[2] = bus.inst2Packet_i; pk[3] = bus.inst3Packet_i;
            if (bus.flush_i) begin
                expQ.delete();
            end else begin
                nd = bus.decStall_i ? 0 : $countones(ev);
                repeat (nd) void'(expQ.pop_front());
                if (bus.fs2Ready_i && !es)
                    for (int k = 0; k < 4; k++)
                        if (bus.instValid_i[k]) expQ.push_back(pk[k]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        bus.fs2Ready_i = 0; bus.instValid_i = 0; bus.decStall_i = 0; bus.flush_i = 0;
        bus.inst0Packet_i = '0; bus.inst1Packet_i = '0; bus.inst2Packet_i = '0; bus.inst3Packet_i = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Full bundle with decode stalled: A..D visible next cycle
        s0 = seq;
        cycle(1, 4'b1111, 1, 0);
        cycle(0, 4'b1111, 1, 0);
        @(negedge clk);
        check("d028_occupancy", 128'(bus.occupancy_o), 128'(4));
        check("d028_decValid", 128'(bus.decValid_o), 128'(4'b1111));
        check("d028_dec0", 128'(bus.dec0Packet_o), 128'(mkPkt(s0)));
        check("d028_dec3", 128'(bus.dec3Packet_o), 128'(mkPkt(s0 + 3)));
        cycle(0, 4'b0000, 0, 0);
        cycle(0, 4'b0000, 0, 0);

        // Partial bundle then a full one: compaction keeps order
        s0 = seq;
        cycle(1, 4'b0111, 1, 0);
        cycle(1, 4'b1111, 1, 0);
        @(negedge clk);
        check("d029_occupancy", 128'(bus.occupancy_o), 128'(3));
        check("d029_decValid", 128'(bus.decValid_o), 128'(4'b0111));
        cycle(0, 4'b0000, 1, 0);
        @(negedge clk);
        check("d029_dec3", 128'(bus.dec3Packet_o), 128'(mkPkt(s0 + 4)));
        repeat (3) cycle(0, 4'b0000, 0, 0);

        // Sparse patterns and an empty-valid bundle
        cycle(1, 4'b1010, 1, 0);
        cycle(1, 4'b1001, 1, 0);
        cycle(1, 4'b0000, 1, 0);
        cycle(1, 4'b0100, 0, 0);
        repeat (3) cycle(0, 4'b1111, 0, 0);

        // Fill to full, drop one bundle, then drain
        repeat (4) cycle(1, 4'b1111, 1, 0);
        cycle(1, 4'b1111, 1, 0);
        @(negedge clk);
        check("d030_full_occupancy", 128'(bus.occupancy_o), 128'(16));
        check("d030_full_stall", 128'(bus.fetchStall_o), 128'(1));
        cycle(0, 4'b0000, 1, 0);
        @(negedge clk);
        check("d030_drop_occupancy", 128'(bus.occupancy_o), 128'(16));
        cycle(0, 4'b0000, 0, 0);
        cycle(0, 4'b0000, 0, 0);
        @(negedge clk);
        check("d030_after_deq_occupancy", 128'(bus.occupancy_o), 128'(12));
        check("d030_after_deq_stall", 128'(bus.fetchStall_o), 128'(0));
        repeat (4) cycle(0, 4'b0000, 0, 0);

        // Steady state at 8 with pointer wrap
        cycle(1, 4'b1111, 1, 0);
        cycle(1, 4'b1111, 1, 0);
        repeat (10) cycle(1, 4'b1111, 0, 0);
        cycle(0, 4'b0000, 1, 0);
        @(negedge clk);
        check("d031_occupancy", 128'(bus.occupancy_o), 128'(8));
        repeat (3) cycle(0, 4'b0000, 0, 0);

        // Flush at occupancy 6 with concurrent enqueue
        cycle(1, 4'b1111, 1, 0);
        cycle(1, 4'b0011, 1, 0);
        cycle(1, 4'b1111, 0, 1);
        @(negedge clk);
        check("d032_flush_decValid", 128'(bus.decValid_o), 128'(0));
        s0 = seq;
        cycle(1, 4'b1111, 1, 0);
        @(negedge clk);
        check("d032_post_flush_occupancy", 128'(bus.occupancy_o), 128'(0));
        cycle(0, 4'b0000, 1, 0);
        @(negedge clk);
        check("d032_post_flush_dec0", 128'(bus.dec0Packet_o), 128'(mkPkt(s0)));
        repeat (2) cycle(0, 4'b0000, 0, 0);

        // Async reset pulse between edges at occupancy 10
        cycle(1, 4'b1111, 1, 0);
        cycle(1, 4'b1111, 1, 0);
        cycle(1, 4'b0011, 1, 0);
        cycle(0, 4'b0000, 1, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("d033_occupancy", 128'(bus.occupancy_o), 128'(0));
        check("d033_decValid", 128'(bus.decValid_o), 128'(0));
        check("d033_fetchStall", 128'(bus.fetchStall_o), 128'(0));
        reset = 1'b1;
        s0 = seq;
        cycle(1, 4'b1111, 1, 0);
        cycle(0, 4'b0000, 1, 0);
        @(negedge clk);
        check("d027_first_after_reset", 128'(bus.dec0Packet_o), 128'(mkPkt(s0)));
        repeat (3) cycle(0, 4'b0000, 0, 0);
        @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
